pc_fetch_controller: RTL and testbench

Sequences the program counter and the instruction-memory read port in the fetch stage. Gates PC advance on instruction-memory hit and pipeline stall. Turns branch/jump redirects into a one-shot PC load, including redirects that arrive while a fetch miss is outstanding. Enforces halt and keeps fetch/stall performance counters. Sits between the hazard unit, the PC and the imem side of the memory controller.

---
 rtl/pc_fetch_controller_pkg.sv | 6 +
 rtl/pc_fetch_controller_if.sv | 21 ++
 rtl/pc_fetch_controller_perf_counter.sv | 15 +
 rtl/pc_fetch_controller.sv | 106 ++++++++++
 tb/tb_pc_fetch_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_controller_pkg.sv
// Shared types for the fetch-stage controller: address word and fetch FSM states.
package pc_fetch_controller_pkg;
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;
   typedef enum logic [1:0] {BOOT, FETCH, REDIR_WAIT, HALTED} fetch_state_t;
endpackage

// File: rtl/pc_fetch_controller_if.sv
// Fetch controller signal bundle: hazard/imem inputs, PC/imem controls and counters.
interface pc_fetch_controller_if #(
   parameter int ADDR_W  = 32,
   parameter int COUNT_W = 32
);
   logic               ihit, stall, redirect, halt;
   logic [ADDR_W-1:0]  redirect_addr, load_addr;
   logic               imemREN, pc_en, pc_load, flush, fetch_valid, halted;
   logic [COUNT_W-1:0] fetch_count, stall_count;

   modport master (
      input  ihit, stall, redirect, redirect_addr, halt,
      output imemREN, pc_en, pc_load, load_addr, flush, fetch_valid, halted,
             fetch_count, stall_count
   );
   modport slave (
      output ihit, stall, redirect, redirect_addr, halt,
      input  imemREN, pc_en, pc_load, load_addr, flush, fetch_valid, halted,
             fetch_count, stall_count
   );
endinterface

// File: rtl/pc_fetch_controller_perf_counter.sv
// Wrapping event counter; frz holds the value regardless of en.
module pc_fetch_controller_perf_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         en,
   input  logic         frz,
   output logic [W-1:0] count
);
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)            count <= '0;
      else if (en && !frz)  count <= count + W'(1);
   end
endmodule

// File: rtl/pc_fetch_controller.sv
// Fetch-stage sequencer: gates PC advance, turns redirects into one-shot PC loads
// (deferred through REDIR_WAIT when the imem request is still outstanding), enforces halt.
module pc_fetch_controller
   import pc_fetch_controller_pkg::*;
#(
   parameter int ADDR_W      = WORD_W,
   parameter int COUNT_W     = 32,
   parameter int BOOT_CYCLES = 2
) (
   input  logic                  CLK,
   input  logic                  nRST,
   pc_fetch_controller_if.master fif
);
   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   fetch_state_t      state, nstate;
   logic [3:0]        boot_cnt;
   logic [ADDR_W-1:0] pend_addr;
   logic              pend_we;
   logic              ren, pc_en, pc_load, flush, fv, stall_inc;
   logic [ADDR_W-1:0] load_addr;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= BOOT;
         boot_cnt  <= '0;
         pend_addr <= '0;
      end else begin
         state <= nstate;
         if (state == BOOT) boot_cnt  <= boot_cnt + 4'd1;
         if (pend_we)       pend_addr <= fif.redirect_addr;
      end
   end

   always_comb begin
      nstate    = state;
      ren       = 1'b0;
      pc_en     = 1'b0;
      pc_load   = 1'b0;
      load_addr = '0;
      flush     = 1'b0;
      fv        = 1'b0;
      stall_inc = 1'b0;
      pend_we   = 1'b0;
      case (state)
         BOOT: begin
            if (fif.halt)                   nstate = HALTED;
            else if (boot_cnt == BOOT_LAST) nstate = FETCH;
         end
         FETCH: begin
            ren = 1'b1;
            if (fif.halt) begin
               flush  = 1'b1;
               nstate = HALTED;
            end else if (fif.redirect) begin
               flush = 1'b1;
               if (fif.ihit) begin
                  pc_en     = 1'b1;
                  pc_load   = 1'b1;
                  load_addr = fif.redirect_addr;
               end else begin
                  pend_we = 1'b1;
                  nstate  = REDIR_WAIT;
               end
            end else if (fif.ihit && !fif.stall) begin
               pc_en = 1'b1;
               fv    = 1'b1;
            end else begin
               stall_inc = 1'b1;
            end
         end
         REDIR_WAIT: begin
            // The in-flight request must complete; whatever it returns is discarded.
            ren = 1'b1;
            if (fif.halt) begin
               nstate = HALTED;
            end else begin
               pend_we = fif.redirect;
               if (fif.ihit) begin
                  pc_en     = 1'b1;
                  pc_load   = 1'b1;
                  load_addr = fif.redirect ? fif.redirect_addr : pend_addr;
                  flush     = 1'b1;
                  nstate    = FETCH;
               end
            end
         end
         default: ;
      endcase
   end

   assign fif.imemREN     = ren;
   assign fif.pc_en       = pc_en;
   assign fif.pc_load     = pc_load;
   assign fif.load_addr   = load_addr;
   assign fif.flush       = flush;
   assign fif.fetch_valid = fv;
   assign fif.halted      = (state == HALTED);

   pc_fetch_controller_perf_counter #(.W(COUNT_W)) u_fetch_cnt (
      .CLK(CLK), .nRST(nRST), .en(fv), .frz(state == HALTED), .count(fif.fetch_count)
   );
   pc_fetch_controller_perf_counter #(.W(COUNT_W)) u_stall_cnt (
      .CLK(CLK), .nRST(nRST), .en(stall_inc), .frz(state == HALTED), .count(fif.stall_count)
   );
endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: directed scenarios plus random traffic against a behavioural model.
module tb_pc_fetch_controller;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   pc_fetch_controller_if #(.ADDR_W(32), .COUNT_W(32)) fif();
   pc_fetch_controller #(.ADDR_W(32), .COUNT_W(32), .BOOT_CYCLES(2)) dut (
      .CLK(CLK), .nRST(nRST), .fif(fif.master)
   );

   typedef struct packed {
      logic        ren, pc_en, pc_load;
      logic [31:0] addr;
      logic        flush, fv, halted;
      logic [31:0] fc, sc;
   } out_t;

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model: cycles left in boot, waiting-for-hit flag, pending target.
   int          boot_left;
   bit          waiting, is_halted, exp_sinc;
   logic [31:0] pend, fc, sc;
   out_t        exp_o, obs;

   function automatic out_t sample();
      out_t o;
      o = '{ren: fif.imemREN, pc_en: fif.pc_en, pc_load: fif.pc_load, addr: fif.load_addr,
            flush: fif.flush, fv: fif.fetch_valid, halted: fif.halted,
            fc: fif.fetch_count, sc: fif.stall_count};
      return o;
   endfunction

   function automatic void model_reset();
      boot_left = 2; waiting = 0; is_halted = 0; pend = 0; fc = 0; sc = 0;
   endfunction

   function automatic void model_eval();
      out_t e;
      e = '0;
      e.fc = fc; e.sc = sc;
      exp_sinc = 0;
      if (is_halted) e.halted = 1;
      else if (boot_left > 0) e.ren = 0;
      else begin
         e.ren = 1;
         if (fif.halt) e.flush = !waiting;
         else if (waiting) begin
            if (fif.ihit) begin
               e.pc_en = 1; e.pc_load = 1; e.flush = 1;
               e.addr = fif.redirect ? fif.redirect_addr : pend;
            end
         end else if (fif.redirect) begin
            e.flush = 1;
            if (fif.ihit) begin e.pc_en = 1; e.pc_load = 1; e.addr = fif.redirect_addr; end
         end else if (fif.ihit && !fif.stall) begin
            e.pc_en = 1; e.fv = 1;
         end else exp_sinc = 1;
      end
      exp_o = e;
      obs = sample();
   endfunction

   function automatic void model_commit();
      if (is_halted) return;
      if (exp_o.fv) fc = fc + 1;
      if (exp_sinc) sc = sc + 1;
      if (fif.halt) is_halted = 1;
      else if (boot_left > 0) boot_left--;
      else if (waiting) begin
         if (fif.redirect) pend = fif.redirect_addr;
         if (fif.ihit) waiting = 0;
      end else if (fif.redirect && !fif.ihit) begin
         pend = fif.redirect_addr; waiting = 1;
      end
   endfunction

   // Apply inputs just after a rising edge, then evaluate at the falling edge.
   task automatic drive(input bit h, r, s, ih, input logic [31:0] ra);
      fif.halt = h; fif.redirect = r; fif.stall = s; fif.ihit = ih; fif.redirect_addr = ra;
      @(negedge CLK);
      model_eval();
   endtask

   task automatic tick();
      @(posedge CLK);
      model_commit();
      #1;
   endtask

   // Asserts reset (outputs checked by caller while held), releases it before the next falling edge.
   task automatic reset_hold();
      fif.halt = 0; fif.redirect = 0; fif.stall = 0; fif.ihit = 0; fif.redirect_addr = 0;
      nRST = 0;
      #2;
      model_reset();
      model_eval();
   endtask

   task automatic reset_release();
      nRST = 1;
   endtask

   task automatic test_reset();
      @(posedge CLK); #1;
      reset_hold();
      n_vec++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, exp_o); end
      n_vec++;
      if (obs !== out_t'(0)) begin n_bad++; $display("FAIL reset_zero: got %h want 0", obs); end
      reset_release();
   endtask

   task automatic test_boot_fetch();
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 1, 32'h0);
         n_vec++;
         if (obs !== exp_o) begin n_bad++; $display("FAIL boot_cyc%0d: got %h want %h", i, obs, exp_o); end
         n_vec++;
         if (obs.ren !== (i >= 2)) begin n_bad++; $display("FAIL boot_ren%0d: got %b want %b", i, obs.ren, (i >= 2)); end
         if (i == 7) begin
            n_vec++;
            if (obs.fc !== 32'd5) begin n_bad++; $display("FAIL boot_fcount: got %0d want 5", obs.fc); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [31:0] sc0;
      sc0 = sc;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, (i < 3), 1, 32'h0);
         n_vec++;
         if (obs !== exp_o) begin n_bad++; $display("FAIL stall_cyc%0d: got %h want %h", i, obs, exp_o); end
         n_vec++;
         if (obs.pc_en !== (i == 3)) begin n_bad++; $display("FAIL stall_pcen%0d: got %b want %b", i, obs.pc_en, (i == 3)); end
         if (i == 3) begin
            n_vec++;
            if (obs.sc !== sc0 + 32'd3) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", obs.sc, sc0 + 32'd3); end
         end
         tick();
      end
   endtask

   task automatic test_redirect_hit();
      logic [31:0] fc0;
      fc0 = fc;
      drive(0, 1, 0, 1, 32'h40);
      n_vec++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL redir_hit: got %h want %h", obs, exp_o); end
      n_vec++;
      if ({obs.pc_load, obs.addr, obs.flush, obs.fv} !== {1'b1, 32'h40, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL redir_hit_fields: got %b/%h/%b/%b want 1/40/1/0", obs.pc_load, obs.addr, obs.flush, obs.fv);
      end
      tick();
      drive(0, 0, 1, 0, 32'h0);
      n_vec++;
      if (obs.fc !== fc0) begin n_bad++; $display("FAIL redir_hit_fcount: got %0d want %0d", obs.fc, fc0); end
      tick();
   endtask

   task automatic test_redirect_miss();
      drive(0, 1, 0, 0, 32'h100); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, (i == 1), (i == 2), 32'h0);
         n_vec++;
         if (obs !== exp_o) begin n_bad++; $display("FAIL redir_wait%0d: got %h want %h", i, obs, exp_o); end
         n_vec++;
         if ({obs.ren, obs.pc_load, obs.addr, obs.flush} !== {1'b1, (i == 2), (i == 2) ? 32'h100 : 32'h0, (i == 2)}) begin
            n_bad++; $display("FAIL redir_wait_fields%0d: got %b/%b/%h/%b", i, obs.ren, obs.pc_load, obs.addr, obs.flush);
         end
         tick();
      end
   endtask

   task automatic test_redirect_overwrite();
      drive(0, 1, 0, 0, 32'h100); tick();
      drive(0, 1, 1, 0, 32'h200); tick();
      drive(0, 0, 1, 1, 32'h0);
      n_vec++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL redir_ovr: got %h want %h", obs, exp_o); end
      n_vec++;
      if (obs.addr !== 32'h200) begin n_bad++; $display("FAIL redir_ovr_addr: got %h want 200", obs.addr); end
      tick();
   endtask

   task automatic test_halt();
      logic [31:0] fc0, sc0;
      drive(1, 1, 1, 1, 32'h80);
      n_vec++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL halt_cyc: got %h want %h", obs, exp_o); end
      tick();
      fc0 = fc; sc0 = sc;
      for (int i = 0; i < 4; i++) begin
         drive(0, i[0], i[1], 1, 32'h44);
         n_vec++;
         if ({obs.halted, obs.ren, obs.pc_en, obs.fc, obs.sc} !== {1'b1, 1'b0, 1'b0, fc0, sc0}) begin
            n_bad++; $display("FAIL halted%0d: got %b/%b/%b/%0d/%0d want 1/0/0/%0d/%0d",
                              i, obs.halted, obs.ren, obs.pc_en, obs.fc, obs.sc, fc0, sc0);
         end
         tick();
      end
      reset_hold();
      n_vec++;
      if (obs !== out_t'(0)) begin n_bad++; $display("FAIL halt_reset: got %h want 0", obs); end
      reset_release();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            reset_hold();
            n_vec++;
            if (obs !== exp_o) begin n_bad++; $display("FAIL rand_reset%0d: got %h want %h", i, obs, exp_o); end
            reset_release();
         end
         drive($urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) != 0, {$urandom_range(0, 255), 2'b00});
         n_vec++;
         if (obs !== exp_o) begin n_bad++; $display("FAIL rand%0d: got %h want %h", i, obs, exp_o); end
         tick();
      end
   endtask

   initial begin
      fif.halt = 0; fif.redirect = 0; fif.stall = 0; fif.ihit = 0; fif.redirect_addr = 0;
      test_reset();
      test_boot_fetch();
      test_stall();
      test_redirect_hit();
      test_redirect_miss();
      test_redirect_overwrite();
      test_halt();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
